// File: rtl/fc_layer_mac_if.sv
// fc_layer_mac_if
// ---------------
// Bundles the three buses of the fully-connected layer:
//   - activation input   : in_valid / in_ready / in_data
//   - configuration port : cfg_ready / wt_we / bias_we / cfg_addr / cfg_data
//   - result output      : out_valid / out_ready / out_data / out_idx /
//                          out_last / out_sat
// The "master" modport is the side that feeds activations and configuration
// and consumes results.
// The "slave" modport is the layer itself.
// Parameters must match the ones given to fc_layer_mac.
interface fc_layer_mac_if #(
  parameter int IN_CH     = 3,
  parameter int IN_PER_CH = 16,
  parameter int OUT_NUM   = 10,
  parameter int IN_BITS   = 12,
  parameter int W_BITS    = 8,
  parameter int OUT_BITS  = 12
);
  localparam int CA_W  = $clog2(OUT_NUM * IN_CH * IN_PER_CH);
  localparam int IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  // activation input
  logic                     in_valid;
  logic                     in_ready;
  logic [IN_CH*IN_BITS-1:0] in_data;

  // configuration port
  logic                     cfg_ready;
  logic                     wt_we;
  logic                     bias_we;
  logic [CA_W-1:0]          cfg_addr;
  logic [W_BITS-1:0]        cfg_data;

  // result output
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_BITS-1:0]      out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     out_sat;

  modport master (
    output in_valid, in_data,
    output wt_we, bias_we, cfg_addr, cfg_data,
    output out_ready,
    input  in_ready, cfg_ready,
    input  out_valid, out_data, out_idx, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_data,
    input  wt_we, bias_we, cfg_addr, cfg_data,
    input  out_ready,
    output in_ready, cfg_ready,
    output out_valid, out_data, out_idx, out_last, out_sat
  );
endinterface

// File: rtl/fc_layer_mac.sv
// fc_layer_mac
// ------------
// Time-multiplexed fully-connected layer.
// The layer buffers one frame of IN_CH x IN_PER_CH signed activations.
// It then computes OUT_NUM dot products, one multiplier lane per channel.
// Each dot product takes IN_PER_CH cycles, one activation index k per cycle.
// Each result is rounded half-up, arithmetically shifted right by SHIFT and
// saturated to OUT_BITS.
// Results are then presented on a valid/ready output.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset; aborts any frame in progress
//   bus    - fc_layer_mac_if.slave
//              in_*   : activation beats, channel c at [c*IN_BITS +: IN_BITS]
//              cfg_*  : weight/bias writes, accepted only while idle
//              out_*  : result, neuron index, last flag, saturation flag
//
// Weight, bias and activation storage are plain arrays without reset.
// All three are read combinationally (distributed RAM).
// This way the address presented in a CALC cycle is consumed by the MAC in
// that same cycle, which gives exactly IN_PER_CH cycles per neuron.
module fc_layer_mac #(
  parameter int IN_CH     = 3,
  parameter int IN_PER_CH = 16,
  parameter int OUT_NUM   = 10,
  parameter int IN_BITS   = 12,
  parameter int W_BITS    = 8,
  parameter int ACC_BITS  = 28,
  parameter int OUT_BITS  = 12,
  parameter int SHIFT     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_layer_mac_if.slave bus
);

  localparam int WT_DEPTH = OUT_NUM * IN_CH * IN_PER_CH;
  localparam int CA_W     = $clog2(WT_DEPTH);
  localparam int IDX_W    = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int K_W      = (IN_PER_CH > 1) ? $clog2(IN_PER_CH) : 1;
  localparam int P_BITS   = IN_BITS + W_BITS;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [K_W-1:0]   K_LAST = K_W'(IN_PER_CH - 1);
  localparam logic [IDX_W-1:0] O_LAST = IDX_W'(OUT_NUM - 1);

  // The rounding path carries one extra bit so the +half cannot wrap.
  localparam logic signed [ACC_BITS:0] RND_C =
    (ACC_BITS+1)'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
  localparam logic signed [ACC_BITS:0] SAT_MAX =
    (ACC_BITS+1)'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS:0] SAT_MIN =
    (ACC_BITS+1)'(-(1 << (OUT_BITS - 1)));

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]                 state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [IDX_W-1:0]           o_q, o_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       out_sat_q, out_sat_d;

  logic                       buf_we;
  logic                       cfg_ready_w;

  // ---------------------------------------------------------------------------
  // Configuration storage
  // ---------------------------------------------------------------------------
  logic signed [W_BITS-1:0] wt_mem   [WT_DEPTH];
  logic signed [W_BITS-1:0] bias_mem [OUT_NUM];

  logic wt_wr;
  logic bias_wr;

  // Writes are only legal while no frame is in flight, so the weights in use
  // never change under a running computation.
  // A simultaneous bias strobe loses to the weight strobe.
  // Both writes also need an in-range address.
  assign cfg_ready_w = (state_q == ST_FILL) && (k_q == '0);
  assign wt_wr   = cfg_ready_w && bus.wt_we &&
                   ({1'b0, bus.cfg_addr} < (CA_W+1)'(WT_DEPTH));
  assign bias_wr = cfg_ready_w && !bus.wt_we && bus.bias_we &&
                   ({1'b0, bus.cfg_addr} < (CA_W+1)'(OUT_NUM));

  always_ff @(posedge clk) begin
    if (wt_wr) begin
      wt_mem[bus.cfg_addr] <= bus.cfg_data;
    end
    if (bias_wr) begin
      bias_mem[bus.cfg_addr[IDX_W-1:0]] <= bus.cfg_data;
    end
  end

  // Bias needed for the neuron that is about to start.
  // This is neuron 0 when leaving FILL, and o+1 when leaving OUT.
  logic [IDX_W-1:0]           bias_idx;
  logic signed [ACC_BITS-1:0] bias_ext;

  assign bias_idx = ((state_q == ST_OUT) && (o_q != O_LAST)) ? o_q + 1'b1 : '0;
  assign bias_ext = ACC_BITS'(bias_mem[bias_idx]);

  // ---------------------------------------------------------------------------
  // Per-channel activation buffer and multiplier lane
  // ---------------------------------------------------------------------------
  logic signed [ACC_BITS-1:0] lane_prod [IN_CH];

  generate
    for (genvar gi = 0; gi < IN_CH; gi++) begin : g_lane
      logic signed [IN_BITS-1:0] buf_mem [IN_PER_CH];
      logic [CA_W-1:0]           wt_addr;
      logic signed [P_BITS-1:0]  prod;

      always_ff @(posedge clk) begin
        if (buf_we) begin
          buf_mem[k_q] <= bus.in_data[gi*IN_BITS +: IN_BITS];
        end
      end

      // The weight for lane gi of neuron o at activation index k lives at
      // o*IN_CH*IN_PER_CH + gi*IN_PER_CH + k.
      assign wt_addr = CA_W'(int'(o_q) * IN_CH * IN_PER_CH +
                             gi * IN_PER_CH + int'(k_q));

      // Full-precision signed product, then sign-extended to accumulator scale.
      assign prod = P_BITS'(buf_mem[k_q]) * P_BITS'(wt_mem[wt_addr]);
      assign lane_prod[gi] = ACC_BITS'(prod);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Accumulate, round, saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_BITS-1:0] acc_sum;
  logic signed [ACC_BITS:0]   rnd_full;
  logic signed [ACC_BITS:0]   rnd_shift;
  logic signed [OUT_BITS-1:0] res_sat;
  logic                       res_clip;

  always_comb begin
    acc_sum = acc_q;
    for (int c = 0; c < IN_CH; c++) begin
      acc_sum = acc_sum + lane_prod[c];
    end
  end

  // The rounded result is taken from acc_sum rather than acc_q.
  // On the last CALC cycle the final product is still in flight, and the
  // registered result must include it.
  always_comb begin
    rnd_full  = (ACC_BITS+1)'(acc_sum) + RND_C;
    rnd_shift = rnd_full >>> SHIFT;
    res_sat   = OUT_BITS'(rnd_shift);
    res_clip  = 1'b0;
    if (rnd_shift > SAT_MAX) begin
      res_sat  = OUT_BITS'(SAT_MAX);
      res_clip = 1'b1;
    end else if (rnd_shift < SAT_MIN) begin
      res_sat  = OUT_BITS'(SAT_MIN);
      res_clip = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FILL -> CALC -> OUT sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_d        = o_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_sat_d  = out_sat_q;
    buf_we     = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (bus.in_valid) begin
          buf_we = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            o_d     = '0;
            acc_d   = bias_ext;
            state_d = ST_CALC;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      ST_CALC: begin
        acc_d = acc_sum;
        if (k_q == K_LAST) begin
          k_d        = '0;
          out_data_d = res_sat;
          out_sat_d  = res_clip;
          out_last_d = (o_q == O_LAST);
          state_d    = ST_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          k_d = '0;
          if (o_q != O_LAST) begin
            o_d     = o_q + 1'b1;
            acc_d   = bias_ext;
            state_d = ST_CALC;
          end else begin
            o_d     = '0;
            state_d = ST_FILL;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
        k_d     = '0;
        o_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      k_q        <= '0;
      o_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      o_q        <= o_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.cfg_ready = cfg_ready_w;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = o_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fc_layer_mac.sv
// tb_fc_layer_mac
// ---------------
// Randomised and directed frames for fc_layer_mac.
// Expected results come from a plain dot-product model:
//   acc = bias + sum(w*x), then floor((acc + 2^(SHIFT-1)) / 2^SHIFT),
//   then clip to OUT_BITS.
module tb_fc_layer_mac;
  localparam int IN_CH     = 3;
  localparam int IN_PER_CH = 16;
  localparam int OUT_NUM   = 10;
  localparam int IN_BITS   = 12;
  localparam int W_BITS    = 8;
  localparam int ACC_BITS  = 28;
  localparam int OUT_BITS  = 12;
  localparam int SHIFT     = 7;
  localparam int NW        = OUT_NUM * IN_CH * IN_PER_CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_layer_mac_if #(.IN_CH(IN_CH), .IN_PER_CH(IN_PER_CH), .OUT_NUM(OUT_NUM),
                    .IN_BITS(IN_BITS), .W_BITS(W_BITS), .OUT_BITS(OUT_BITS)) bus ();

  fc_layer_mac #(.IN_CH(IN_CH), .IN_PER_CH(IN_PER_CH), .OUT_NUM(OUT_NUM),
                 .IN_BITS(IN_BITS), .W_BITS(W_BITS), .ACC_BITS(ACC_BITS),
                 .OUT_BITS(OUT_BITS), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference configuration and frame
  int w_ref [NW];
  int b_ref [OUT_NUM];
  int act_ref [IN_CH][IN_PER_CH];
  int exp_data [OUT_NUM];
  bit exp_sat [OUT_NUM];

  // observations of the last frame
  int got_data [OUT_NUM];
  int got_idx  [OUT_NUM];
  bit got_last [OUT_NUM];
  bit got_sat  [OUT_NUM];
  int got_lat  [OUT_NUM];
  int hold_bad;
  int in_rdy_busy;
  int cfg_rdy_busy;
  bit rdy_after_fill;
  bit rdy_after_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void compute_model();
    for (int o = 0; o < OUT_NUM; o++) begin
      longint acc = longint'(b_ref[o]);
      longint r;
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < IN_PER_CH; k++)
          acc += longint'(w_ref[o*IN_CH*IN_PER_CH + c*IN_PER_CH + k]) * act_ref[c][k];
      r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      exp_sat[o] = 1'b0;
      if (r > 2047) begin r = 2047; exp_sat[o] = 1'b1; end
      if (r < -2048) begin r = -2048; exp_sat[o] = 1'b1; end
      exp_data[o] = int'(r);
    end
  endfunction

  // Biases first, then weights with bias_we held high as well.
  // The weight strobe must win, so no bias may change during the weight pass.
  task automatic load_cfg();
    for (int o = 0; o < OUT_NUM; o++) begin
      bus.bias_we = 1'b1; bus.cfg_addr = 9'(o); bus.cfg_data = W_BITS'(b_ref[o]);
      tick();
    end
    for (int a = 0; a < NW; a++) begin
      bus.wt_we = 1'b1; bus.bias_we = 1'b1;
      bus.cfg_addr = 9'(a); bus.cfg_data = W_BITS'(w_ref[a]);
      tick();
    end
    bus.wt_we = 1'b0; bus.bias_we = 1'b0;
  endtask

  // Feeds act_ref, then drains all outputs.
  // Activation input stays valid throughout the computation.
  // hold_o  : output index held back hold_n cycles
  // poke    : issue config writes while cfg_ready is low
  // abort_o : assert reset partway into the computation of that output
  task automatic run_frame(input int hold_o, input int hold_n, input bit poke, input int abort_o);
    int n;
    logic [OUT_BITS-1:0] held_data;
    logic [3:0] held_idx;
    hold_bad = 0; in_rdy_busy = 0; cfg_rdy_busy = 0;
    for (int k = 0; k < IN_PER_CH; k++) begin
      bus.in_valid = 1'b1;
      for (int c = 0; c < IN_CH; c++) bus.in_data[c*IN_BITS +: IN_BITS] = IN_BITS'(act_ref[c][k]);
      if (poke && k == 5) begin
        bus.wt_we = 1'b1; bus.bias_we = 1'b1;
        bus.cfg_addr = 9'($urandom_range(0, OUT_NUM-1)); bus.cfg_data = W_BITS'($urandom);
      end
      tick();
      bus.wt_we = 1'b0; bus.bias_we = 1'b0;
    end
    rdy_after_fill = bus.in_ready;
    bus.in_data = (IN_CH*IN_BITS)'($urandom);
    for (int o = 0; o < OUT_NUM; o++) begin
      if (o == abort_o) begin
        repeat (4) tick();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        return;
      end
      n = 0;
      while (!bus.out_valid && n < 200) begin
        if (bus.in_ready) in_rdy_busy++;
        if (bus.cfg_ready) cfg_rdy_busy++;
        if (poke && n == 2) begin
          bus.wt_we = 1'b1; bus.bias_we = 1'b1;
          bus.cfg_addr = 9'($urandom_range(0, NW-1)); bus.cfg_data = W_BITS'($urandom);
        end
        tick();
        bus.wt_we = 1'b0; bus.bias_we = 1'b0;
        n++;
      end
      got_lat[o]  = bus.out_valid ? n : -1;
      got_data[o] = int'($signed(bus.out_data));
      got_idx[o]  = int'(bus.out_idx);
      got_last[o] = bus.out_last;
      got_sat[o]  = bus.out_sat;
      if (o == hold_o) begin
        held_data = bus.out_data; held_idx = bus.out_idx;
        for (int h = 0; h < hold_n; h++) begin
          tick();
          if (!bus.out_valid || bus.out_data !== held_data || bus.out_idx !== held_idx || bus.in_ready)
            hold_bad++;
        end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    bus.in_valid = 1'b0;
    rdy_after_last = bus.in_ready;
    $display("frame: out0=%0d out9=%0d lat0=%0d", got_data[0], got_data[OUT_NUM-1], got_lat[0]);
  endtask

  task automatic test_reset();
    tick(); tick();
    checks += 7;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
    if (bus.out_idx !== '0) begin failures++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
    if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got %b want 0", bus.out_sat); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    for (int a = 0; a < NW; a++) w_ref[a] = 1;
    for (int o = 0; o < OUT_NUM; o++) b_ref[o] = 0;
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = 64;
    load_cfg();
    compute_model();
    run_frame(-1, 0, 0, -1);
    for (int o = 0; o < OUT_NUM; o++) begin
      checks += 5;
      if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL basic_data[%0d] got %0d want %0d", o, got_data[o], exp_data[o]); end
      if (got_idx[o] !== o) begin failures++; $display("FAIL basic_idx[%0d] got %0d want %0d", o, got_idx[o], o); end
      if (got_last[o] !== (o == OUT_NUM-1)) begin failures++; $display("FAIL basic_last[%0d] got %b", o, got_last[o]); end
      if (got_sat[o] !== exp_sat[o]) begin failures++; $display("FAIL basic_sat[%0d] got %b want %b", o, got_sat[o], exp_sat[o]); end
      if (got_lat[o] !== IN_PER_CH) begin failures++; $display("FAIL basic_latency[%0d] got %0d want %0d", o, got_lat[o], IN_PER_CH); end
    end
    checks += 3;
    if (rdy_after_fill !== 1'b0) begin failures++; $display("FAIL in_ready_after_fill got %b want 0", rdy_after_fill); end
    if (rdy_after_last !== 1'b1) begin failures++; $display("FAIL in_ready_after_last got %b want 1", rdy_after_last); end
    if (in_rdy_busy !== 0) begin failures++; $display("FAIL in_ready_busy got %0d want 0", in_rdy_busy); end
  endtask

  task automatic test_rounding();
    int vals [4] = '{64, 63, -64, -65};
    for (int a = 0; a < NW; a++) w_ref[a] = 0;
    w_ref[0] = 1;
    for (int o = 0; o < OUT_NUM; o++) b_ref[o] = 0;
    load_cfg();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 4095)) - 2048;
      act_ref[0][0] = vals[i];
      compute_model();
      run_frame(-1, 0, 0, -1);
      checks += 2;
      if (got_data[0] !== exp_data[0]) begin failures++; $display("FAIL round_out0 x=%0d got %0d want %0d", vals[i], got_data[0], exp_data[0]); end
      if (got_data[1] !== exp_data[1]) begin failures++; $display("FAIL round_out1 x=%0d got %0d want %0d", vals[i], got_data[1], exp_data[1]); end
    end
  endtask

  task automatic test_saturation();
    int wv [2] = '{127, -128};
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < NW; a++) w_ref[a] = wv[i];
      for (int o = 0; o < OUT_NUM; o++) b_ref[o] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = 2047;
      load_cfg();
      compute_model();
      run_frame(-1, 0, 0, -1);
      for (int o = 0; o < OUT_NUM; o += 3) begin
        checks += 2;
        if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL sat_data w=%0d [%0d] got %0d want %0d", wv[i], o, got_data[o], exp_data[o]); end
        if (got_sat[o] !== exp_sat[o]) begin failures++; $display("FAIL sat_flag w=%0d [%0d] got %b want %b", wv[i], o, got_sat[o], exp_sat[o]); end
      end
    end
  endtask

  task automatic test_bias_index();
    for (int a = 0; a < NW; a++) w_ref[a] = 0;
    for (int o = 0; o < OUT_NUM; o++) b_ref[o] = o * 10;
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 4095)) - 2048;
    load_cfg();
    compute_model();
    run_frame(-1, 0, 0, -1);
    for (int o = 0; o < OUT_NUM; o++) begin
      checks += 2;
      if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL bias_data[%0d] got %0d want %0d", o, got_data[o], exp_data[o]); end
      if (got_idx[o] !== o) begin failures++; $display("FAIL bias_idx[%0d] got %0d want %0d", o, got_idx[o], o); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int a = 0; a < NW; a++) w_ref[a] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < OUT_NUM; o++) b_ref[o] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 1023)) - 512;
      load_cfg();
      compute_model();
      run_frame(-1, 0, 0, -1);
      for (int o = 0; o < OUT_NUM; o++) begin
        checks += 2;
        if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL rand%0d_data[%0d] got %0d want %0d", it, o, got_data[o], exp_data[o]); end
        if (got_sat[o] !== exp_sat[o]) begin failures++; $display("FAIL rand%0d_sat[%0d] got %b want %b", it, o, got_sat[o], exp_sat[o]); end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 1023)) - 512;
    compute_model();
    run_frame(3, 5, 0, -1);
    checks += 4;
    if (hold_bad !== 0) begin failures++; $display("FAIL bp_hold_stable got %0d bad cycles want 0", hold_bad); end
    if (got_lat[4] !== IN_PER_CH) begin failures++; $display("FAIL bp_latency4 got %0d want %0d", got_lat[4], IN_PER_CH); end
    if (got_data[3] !== exp_data[3]) begin failures++; $display("FAIL bp_data3 got %0d want %0d", got_data[3], exp_data[3]); end
    if (in_rdy_busy !== 0) begin failures++; $display("FAIL bp_in_ready_busy got %0d want 0", in_rdy_busy); end
  endtask

  task automatic test_cfg_gating();
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 1023)) - 512;
    compute_model();
    run_frame(-1, 0, 1, -1);
    checks += 1;
    if (cfg_rdy_busy !== 0) begin failures++; $display("FAIL gate_cfg_ready_busy got %0d want 0", cfg_rdy_busy); end
    // a second frame shows that no write leaked in during the first
    run_frame(-1, 0, 0, -1);
    for (int o = 0; o < OUT_NUM; o++) begin
      checks += 1;
      if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL gate_data[%0d] got %0d want %0d", o, got_data[o], exp_data[o]); end
    end
  endtask

  task automatic test_reset_midframe();
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 1023)) - 512;
    run_frame(-1, 0, 0, 5);
    checks += 4;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_idx !== '0) begin failures++; $display("FAIL rst_mid_out_idx got %0d want 0", bus.out_idx); end
    if (bus.out_data !== '0) begin failures++; $display("FAIL rst_mid_out_data got %0d want 0", bus.out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < IN_PER_CH; k++) act_ref[c][k] = int'($urandom_range(0, 1023)) - 512;
    compute_model();
    run_frame(-1, 0, 0, -1);
    for (int o = 0; o < OUT_NUM; o++) begin
      checks += 2;
      if (got_data[o] !== exp_data[o]) begin failures++; $display("FAIL rst_next_data[%0d] got %0d want %0d", o, got_data[o], exp_data[o]); end
      if (got_idx[o] !== o) begin failures++; $display("FAIL rst_next_idx[%0d] got %0d want %0d", o, got_idx[o], o); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.wt_we = 1'b0; bus.bias_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_bias_index();
    test_random();
    test_backpressure();
    test_cfg_gating();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
